avmm_vram_reader: RTL

Avalon-MM read master that streams a frame buffer out of video RAM. It issues pipelined byte reads to the VRAM controller's read slave port and buffers the returned bytes in a small FIFO. The bytes are presented as a ready/valid pixel stream to the display timing generator. It sits between the VRAM controller and the VGA output path and is the consumer end of the controller's VRAM read interface.

---
 rtl/vram_pkg.sv | 13 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/avmm_vram_reader.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// Shared VRAM interface widths and the reader FSM state encoding.
package vram_pkg;

  localparam int VRAM_ADDR_WIDTH = 19;
  localparam int VRAM_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and synchronous flush.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_do_rd;
  logic             w_do_wr;

  assign empty   = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_do_rd = rd_en & ~empty;
  assign w_do_wr = wr_en & (~w_full | w_do_rd);
  assign count   = r_count;
  // Head word is visible without a read strobe; zero when empty so the output is defined.
  assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + {{(CW-1){1'b0}}, w_do_wr} - {{(CW-1){1'b0}}, w_do_rd};
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr && !flush) r_mem[r_wr_ptr] <= wr_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_en && w_full && !w_do_rd && !flush));

endmodule

// File: rtl/avmm_vram_reader.sv
// Avalon-MM read master streaming a frame buffer from VRAM into a pixel FIFO.
module avmm_vram_reader
  import vram_pkg::*;
#(
  parameter int FRAME_BYTES = 307200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       frame_start,
  output logic [VRAM_ADDR_WIDTH-1:0] avm_vram_address,
  output logic                       avm_vram_read,
  input  logic                       avm_vram_waitrequest,
  input  logic [VRAM_DATA_WIDTH-1:0] avm_vram_readdata,
  input  logic                       avm_vram_readdatavalid,
  output logic [VRAM_DATA_WIDTH-1:0] pixel_data,
  output logic                       pixel_valid,
  input  logic                       pixel_ready,
  output logic                       frame_done,
  output logic                       underflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [VRAM_ADDR_WIDTH-1:0] LAST_ADDR = VRAM_ADDR_WIDTH'(FRAME_BYTES - 1);

  state_t                     r_state;
  state_t                     w_next_state;
  logic [VRAM_ADDR_WIDTH-1:0] r_addr;
  logic                       r_read;
  logic                       r_held;
  logic                       r_pending;
  logic                       r_done;
  logic                       r_underflow;
  logic [CW-1:0]              r_outstanding;
  logic [CW-1:0]              r_discard;
  logic [CW-1:0]              w_out_next;
  logic [CW-1:0]              w_fifo_count;
  logic [CW-1:0]              w_fifo_count_next;
  logic [CW:0]                w_credit_sum;
  logic                       w_credit_ok;
  logic                       w_read_next;
  logic                       w_fetching;
  logic                       w_fs;
  logic                       w_stall;
  logic                       w_accept;
  logic                       w_apply;
  logic                       w_last_accept;
  logic                       w_drop;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_fifo_empty;
  logic [VRAM_DATA_WIDTH-1:0] w_fifo_data;

  // A fresh request is withheld while a restart is waiting; a stalled one must be held.
  assign w_fs          = frame_start | r_pending;
  assign avm_vram_read = r_read & (r_held | ~w_fs);
  assign w_stall       = avm_vram_read & avm_vram_waitrequest;
  assign w_accept      = avm_vram_read & ~avm_vram_waitrequest;
  assign w_apply       = w_fs & ~w_stall;
  assign w_last_accept = w_accept & (r_addr == LAST_ADDR);

  assign w_drop = avm_vram_readdatavalid & (w_apply | (r_discard != '0));
  assign w_push = avm_vram_readdatavalid & ~w_drop;
  assign w_pop  = pixel_valid & pixel_ready;

  assign avm_vram_address = r_addr;
  assign pixel_valid      = ~w_fifo_empty;
  assign pixel_data       = w_fifo_data;
  assign frame_done       = r_done;
  assign underflow        = r_underflow;

  assign w_out_next = r_outstanding + {{(CW-1){1'b0}}, w_accept}
                                    - {{(CW-1){1'b0}}, avm_vram_readdatavalid};
  assign w_fifo_count_next = w_apply ? '0 :
    w_fifo_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
  // Credit is judged on next-cycle occupancy because the read strobe is registered.
  assign w_credit_sum = {1'b0, w_fifo_count_next} + {1'b0, w_out_next};
  assign w_credit_ok  = (w_credit_sum < (CW+1)'(FIFO_DEPTH));

  sync_fifo #(
    .WIDTH (VRAM_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (w_apply),
    .wr_en   (w_push),
    .wr_data (avm_vram_readdata),
    .rd_en   (w_pop),
    .rd_data (w_fifo_data),
    .empty   (w_fifo_empty),
    .count   (w_fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (w_apply) begin
      w_next_state = enable ? FETCH : IDLE;
    end else begin
      case (r_state)
        IDLE:    if (enable && r_addr == '0) w_next_state = FETCH;
        FETCH:   if (w_last_accept)          w_next_state = DONE;
                 else if (!enable && !w_stall) w_next_state = IDLE;
        DONE:    if (!enable)                w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    w_read_next = 1'b0;
    w_fetching  = (r_state == FETCH);
    if (w_stall)                    w_read_next = 1'b1;
    else if (w_next_state == FETCH) w_read_next = w_credit_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr        <= '0;
      r_read        <= 1'b0;
      r_held        <= 1'b0;
      r_pending     <= 1'b0;
      r_done        <= 1'b0;
      r_underflow   <= 1'b0;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_read        <= w_read_next;
      r_held        <= w_stall;
      r_outstanding <= w_out_next;
      r_underflow   <= pixel_ready & ~pixel_valid & w_fetching;
      r_pending     <= w_apply ? 1'b0 : (r_pending | frame_start);
      if (w_apply) begin
        r_addr    <= '0;
        r_done    <= 1'b0;
        // Everything still in flight after this edge belongs to the old frame.
        r_discard <= w_out_next;
      end else begin
        if (w_accept) r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + VRAM_ADDR_WIDTH'(1);
        if (w_last_accept) r_done <= 1'b1;
        if (avm_vram_readdatavalid && r_discard != '0) r_discard <= r_discard - CW'(1);
      end
    end
  end

endmodule
